program_loader: RTL
===================

// Module: program_loader
// PURPOSE
//  Boot-time writer for the ProgramMemory write port (MEMWRITE/ADDR/WRITE_DATA).
//  - Takes a byte stream (valid/ready), packs bytes into 32-bit words and writes them to consecutive addresses.
//  - Holds the CPU in reset (CPU_HOLD) while a load is active.
//  - Sits between the host link (UART RX etc.) and the program memory; its write outputs drive the memory directly.
// PARAMETERS
//  DEPTH      32  max words per load; memory word count
//  BASE_ADDR  0   address of first word written (word-indexed, as memory ADDR)
// PORTS
//  CLK         in   1   single clock; all state updates on posedge
//  RESET_N     in   1   asynchronous, active-low reset
//  START       in   1   one-cycle pulse; begins a load from IDLE or DONE
//  IN_VALID    in   1   byte on IN_DATA valid
//  IN_DATA     in   8   stream byte
//  IN_READY    out  1   loader accepts byte this cycle
//  MEMWRITE    out  1   one-cycle write strobe to program memory
//  MEMREAD     out  1   constant 0 (loader never reads)
//  ADDR        out  32  word address, registered
//  WRITE_DATA  out  32  packed word, registered
//  CPU_HOLD    out  1   high from START until DONE reached
//  LOAD_DONE   out  1   high in DONE with no error
//  LOAD_ERR    out  1   high in DONE when load failed
//  WORD_CNT    out  6   words written so far in current load
// BEHAVIOUR
//  - Reset (async, RESET_N=0): state IDLE.
//    - Outputs: IN_READY=0, MEMWRITE=0, ADDR=0, WRITE_DATA=0, CPU_HOLD=0, LOAD_DONE=0, LOAD_ERR=0, WORD_CNT=0.
//    - A partially packed word is discarded. Memory contents are untouched.
//  - Byte accepted on posedge when IN_VALID & IN_READY. IN_VALID while IN_READY=0 is ignored, not lost-counted.
//  - States:
//    - IDLE: START -> LEN. Clears flags and WORD_CNT, CPU_HOLD=1.
//    - LEN: IN_READY=1. First byte = N.
//      - N=0 -> DONE, no writes, LOAD_DONE=1.
//      - N>DEPTH -> DONE with LOAD_ERR=1, no writes.
//      - Otherwise -> COLLECT.
//    - COLLECT: IN_READY=1. Bytes packed LSB first (byte0 -> [7:0] ... byte3 -> [31:24]). On the 4th byte -> WRITE.
//    - WRITE: IN_READY=0. MEMWRITE=1 for exactly one cycle, ADDR=BASE_ADDR+WORD_CNT, WRITE_DATA=packed word.
//      - ADDR and WRITE_DATA are stable for the full cycle; memory samples on negedge.
//      - Next posedge: WORD_CNT+1. If WORD_CNT+1==N -> DONE (or CSUM), else COLLECT.
//    - DONE: CPU_HOLD=0, IN_READY=0, flags held. START -> LEN (restart; flags, WORD_CNT cleared).
//  - Latency: 4th byte accepted at edge k -> MEMWRITE high cycle k+1 -> next byte accepted no earlier than edge k+3.
//  - MEMWRITE and ADDR are 0 outside WRITE. ADDR never exceeds BASE_ADDR+DEPTH-1.
//  - START outside IDLE/DONE is ignored. START coinciding with an accepted byte: the byte is processed, START ignored.
//  - WORD_CNT saturates at DEPTH (6 bits covers DEPTH<=63).
// CONFIGURATION
//  - LOADER_CHECKSUM_EN defined:
//    - After the last WRITE, state CSUM (IN_READY=1) takes one byte and compares it to the XOR of all 4N data bytes.
//    - Match -> DONE with LOAD_DONE=1. Mismatch -> DONE with LOAD_ERR=1 (words already written stay).
//    - N=0 skips CSUM.
//  - Undefined: no CSUM state; DONE follows the last WRITE directly; LOAD_ERR is set only for N>DEPTH.
// TESTING
//  - Reset: pull RESET_N low mid-COLLECT (2 bytes in) -> all outputs 0 and state IDLE at once, without waiting for a clock.
//    - START + N=1 + 4 bytes then writes only the new word at ADDR 0.
//  - START, N=2, bytes 78 56 34 12 EF BE AD DE:
//    - Required writes: MEMWRITE pulse ADDR=0 data=0x12345678, then ADDR=1 data=0xDEADBEEF.
//    - Then LOAD_DONE=1, CPU_HOLD=0, WORD_CNT=2.
//  - Backpressure: hold IN_VALID=1 continuously.
//    - IN_READY=0 during each WRITE cycle; no byte is dropped or duplicated; exactly one MEMWRITE per 4 bytes.
//  - Length bounds:
//    - N=0 -> DONE, LOAD_DONE=1, no MEMWRITE.
//    - N=33 with DEPTH=32 -> LOAD_ERR=1, no MEMWRITE.
//    - N=32 -> last write at ADDR=31.
//  - START at different points:
//    - START during COLLECT -> no effect.
//    - START in DONE -> flags clear, CPU_HOLD=1, a new load runs.
//  - LOADER_CHECKSUM_EN, N=1, bytes 01 02 03 04:
//    - Trailer 04 -> LOAD_DONE=1.
//    - Trailer 05 -> LOAD_ERR=1, word 0x04030201 still written.

Source files
------------

// File: rtl/program_loader_if.sv
// -----------------------------------------------------------------------------
// program_loader_if
//  Bundles the signals between the program loader, its byte source and the
//  program memory write port.
//
//  Signals
//   START       host -> loader   one-cycle pulse that begins a load
//   IN_VALID    host -> loader   IN_DATA holds a valid stream byte
//   IN_DATA     host -> loader   8-bit stream byte
//   IN_READY    loader -> host   loader accepts a byte this cycle
//   MEMWRITE    loader -> mem    one-cycle write strobe
//   MEMREAD     loader -> mem    tied low, the loader never reads
//   ADDR        loader -> mem    32-bit word address
//   WRITE_DATA  loader -> mem    32-bit packed word
//   CPU_HOLD    loader -> cpu    keeps the CPU in reset while loading
//   LOAD_DONE   loader -> host   load finished without error
//   LOAD_ERR    loader -> host   load finished with an error
//   WORD_CNT    loader -> host   words written in the current load
//
//  Modports
//   master : the host/stream side (drives START and the byte stream)
//   slave  : the loader itself
// -----------------------------------------------------------------------------
interface program_loader_if;
  logic        START;
  logic        IN_VALID;
  logic [7:0]  IN_DATA;
  logic        IN_READY;
  logic        MEMWRITE;
  logic        MEMREAD;
  logic [31:0] ADDR;
  logic [31:0] WRITE_DATA;
  logic        CPU_HOLD;
  logic        LOAD_DONE;
  logic        LOAD_ERR;
  logic [5:0]  WORD_CNT;

  modport master (
    output START, IN_VALID, IN_DATA,
    input  IN_READY, MEMWRITE, MEMREAD, ADDR, WRITE_DATA,
    input  CPU_HOLD, LOAD_DONE, LOAD_ERR, WORD_CNT
  );

  modport slave (
    input  START, IN_VALID, IN_DATA,
    output IN_READY, MEMWRITE, MEMREAD, ADDR, WRITE_DATA,
    output CPU_HOLD, LOAD_DONE, LOAD_ERR, WORD_CNT
  );
endinterface

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//  Boot-time writer for the program memory. A load starts with a START pulse,
//  takes a length byte N and then 4*N stream bytes, packs them LSB first into
//  32-bit words and writes them to consecutive word addresses starting at
//  BASE_ADDR. The CPU is held in reset while a load is in progress.
//
//  Optional feature (macro LOADER_CHECKSUM_EN): after the last word a trailer
//  byte is taken and compared with the XOR of all data bytes; a mismatch ends
//  the load with LOAD_ERR.
//
//  Parameters
//   DEPTH      maximum words per load (<= 63)
//   BASE_ADDR  word address of the first word written
//
//  Ports
//   CLK      clock, everything updates on posedge
//   RESET_N  asynchronous active-low reset
//   bus      program_loader_if.slave (stream in, memory write port out,
//            CPU_HOLD / status out); all outputs are registered
// -----------------------------------------------------------------------------
module program_loader #(
  parameter int          DEPTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input logic             CLK,
  input logic             RESET_N,
  program_loader_if.slave bus
);

  localparam logic [5:0] DEPTH_C = 6'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_COLLECT = 3'd2,
    S_WRITE   = 3'd3,
    S_CSUM    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t      state_r, state_s;
  logic [7:0]  len_r, len_s;
  logic [1:0]  byte_idx_r, byte_idx_s;
  logic [23:0] pack_r, pack_s;
  logic [5:0]  word_cnt_r, word_cnt_s;
  logic [5:0]  cnt_inc_s;
  logic [31:0] write_data_r, write_data_s;
  logic        load_done_r, load_done_s;
  logic        load_err_r, load_err_s;
  logic        in_ready_r, in_ready_s;
  logic        memwrite_r, memwrite_s;
  logic [31:0] addr_r, addr_s;
  logic        cpu_hold_r, cpu_hold_s;
  logic        accept_s;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_r, csum_s;

  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction
`endif

  assign accept_s = bus.IN_VALID & in_ready_r;

  // Saturating successor of the word counter.
  assign cnt_inc_s = (word_cnt_r == DEPTH_C) ? word_cnt_r : (word_cnt_r + 6'd1);

  // Next-state and datapath update logic of the load sequencer.
  always_comb begin
    state_s      = state_r;
    len_s        = len_r;
    byte_idx_s   = byte_idx_r;
    pack_s       = pack_r;
    word_cnt_s   = word_cnt_r;
    write_data_s = write_data_r;
    load_done_s  = load_done_r;
    load_err_s   = load_err_r;
`ifdef LOADER_CHECKSUM_EN
    csum_s       = csum_r;
`endif
    case (state_r)
      S_IDLE, S_DONE: begin
        if (bus.START) begin
          state_s     = S_LEN;
          word_cnt_s  = 6'd0;
          byte_idx_s  = 2'd0;
          load_done_s = 1'b0;
          load_err_s  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          csum_s      = 8'd0;
`endif
        end else begin
          state_s = state_r;
        end
      end
      S_LEN: begin
        if (accept_s) begin
          len_s = bus.IN_DATA;
          if (bus.IN_DATA == 8'd0) begin
            state_s     = S_DONE;
            load_done_s = 1'b1;
          end else if (bus.IN_DATA > {2'b00, DEPTH_C}) begin
            state_s    = S_DONE;
            load_err_s = 1'b1;
          end else begin
            state_s = S_COLLECT;
          end
        end else begin
          state_s = S_LEN;
        end
      end
      S_COLLECT: begin
        if (accept_s) begin
          byte_idx_s = byte_idx_r + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_s     = csum_fold(csum_r, bus.IN_DATA);
`endif
          case (byte_idx_r)
            2'd0:    pack_s[7:0]   = bus.IN_DATA;
            2'd1:    pack_s[15:8]  = bus.IN_DATA;
            2'd2:    pack_s[23:16] = bus.IN_DATA;
            2'd3: begin
              write_data_s = {bus.IN_DATA, pack_r};
              state_s      = S_WRITE;
            end
            default: pack_s = pack_r;
          endcase
        end else begin
          state_s = S_COLLECT;
        end
      end
      S_WRITE: begin
        word_cnt_s = cnt_inc_s;
        if ({2'b00, cnt_inc_s} == len_r) begin
`ifdef LOADER_CHECKSUM_EN
          state_s = S_CSUM;
`else
          state_s     = S_DONE;
          load_done_s = 1'b1;
`endif
        end else begin
          state_s = S_COLLECT;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept_s) begin
          state_s = S_DONE;
          if (bus.IN_DATA == csum_r) begin
            load_done_s = 1'b1;
          end else begin
            load_err_s = 1'b1;
          end
        end else begin
          state_s = S_CSUM;
        end
      end
`endif
      default: state_s = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_s)
      // The cycle following a write keeps IN_READY low, so the next byte is
      // taken no earlier than two edges after the write strobe ends.
      S_LEN, S_COLLECT: in_ready_s = (state_r != S_WRITE);
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:           in_ready_s = (state_r != S_WRITE);
`endif
      default:          in_ready_s = 1'b0;
    endcase
    memwrite_s = (state_s == S_WRITE);
    if (memwrite_s) begin
      addr_s = BASE_ADDR + {26'd0, word_cnt_s};
    end else begin
      addr_s = 32'd0;
    end
    cpu_hold_s = (state_s != S_IDLE) && (state_s != S_DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r      <= S_IDLE;
      len_r        <= 8'd0;
      byte_idx_r   <= 2'd0;
      pack_r       <= 24'd0;
      word_cnt_r   <= 6'd0;
      write_data_r <= 32'd0;
      load_done_r  <= 1'b0;
      load_err_r   <= 1'b0;
      in_ready_r   <= 1'b0;
      memwrite_r   <= 1'b0;
      addr_r       <= 32'd0;
      cpu_hold_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      len_r        <= len_s;
      byte_idx_r   <= byte_idx_s;
      pack_r       <= pack_s;
      word_cnt_r   <= word_cnt_s;
      write_data_r <= write_data_s;
      load_done_r  <= load_done_s;
      load_err_r   <= load_err_s;
      in_ready_r   <= in_ready_s;
      memwrite_r   <= memwrite_s;
      addr_r       <= addr_s;
      cpu_hold_r   <= cpu_hold_s;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of the data bytes of the current load.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      csum_r <= 8'd0;
    end else begin
      csum_r <= csum_s;
    end
  end
`endif

  assign bus.IN_READY   = in_ready_r;
  assign bus.MEMWRITE   = memwrite_r;
  assign bus.MEMREAD    = 1'b0;
  assign bus.ADDR       = addr_r;
  assign bus.WRITE_DATA = write_data_r;
  assign bus.CPU_HOLD   = cpu_hold_r;
  assign bus.LOAD_DONE  = load_done_r;
  assign bus.LOAD_ERR   = load_err_r;
  assign bus.WORD_CNT   = word_cnt_r;

endmodule
